if_id_queue: RTL and testbench

- Decoupling buffer between the instruction-fetch stage (pc_reg + rom) and the decode stage.
- Captures each fetched {pc, inst} pair and presents it to decode in order, using a valid/ready handshake.
- Absorbs decode stalls without losing fetched instructions.
- Discards all in-flight instructions on a branch/jump flush.

---
 rtl/if_id_queue.sv | 108 ++++++++++
 tb/tb_if_id_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
`default_nettype none
//============================================================================
// Module   : if_id_queue
// Purpose  : In-order decoupling buffer between instruction fetch and decode.
//            Captures {pc, inst} pairs from fetch with a valid/ready
//            handshake, presents them to decode in order, absorbs decode
//            stalls and discards everything on a branch/jump flush.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            if_valid_i      - fetch offers an entry this cycle
//            if_pc_i         - PC of the offered entry
//            if_inst_i       - instruction word of the offered entry
//            if_ready_o      - queue can accept an entry (count < DEPTH)
//            id_valid_o      - head entry is valid (count != 0)
//            id_pc_o         - PC of head entry (0 when empty)
//            id_inst_o       - instruction of head entry (NOP_INST when empty)
//            id_ready_i      - decode consumes the head this cycle
//            flush_i         - redirect; clears the queue, beats push/pop
//            count_o         - current occupancy
// Revision : 1.0 - initial release
//============================================================================
module if_id_queue #(
   parameter int                DEPTH    = 4,
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_valid_i,
   input  logic [ADDR_W-1:0]        if_pc_i,
   input  logic [INST_W-1:0]        if_inst_i,
   output logic                     if_ready_o,
   output logic                     id_valid_o,
   output logic [ADDR_W-1:0]        id_pc_o,
   output logic [INST_W-1:0]        id_inst_o,
   input  logic                     id_ready_i,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int                PTR_W   = $clog2(DEPTH);
   localparam int                CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];

   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic              push;
   logic              pop;

   // Handshake flags come from registered occupancy only, so there is no
   // combinational path from id_ready_i to if_ready_o (no bypass when full).
   assign if_ready_o = (count_q < C_DEPTH);
   assign id_valid_o = (count_q != '0);
   assign count_o    = count_q;

   assign id_pc_o    = id_valid_o ? pc_mem[rptr_q]   : '0;
   assign id_inst_o  = id_valid_o ? inst_mem[rptr_q] : NOP_INST;

   assign push = if_valid_i & if_ready_o & ~flush_i;
   assign pop  = id_valid_o & id_ready_i & ~flush_i;

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + PTR_W'(1);
         if (pop)  rptr_d = rptr_q + PTR_W'(1);
         // Full/empty are tracked by count alone; pointers just wrap.
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wptr_q]   <= if_pc_i;
         inst_mem[wptr_q] <= if_inst_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_id_queue.sv
`default_nettype none
//============================================================================
// Module   : tb_if_id_queue
// Purpose  : Directed self-checking bench for if_id_queue (DEPTH=4).
// Revision : 1.0 - initial release
//============================================================================
module tb_if_id_queue;

   logic        clk;
   logic        rst;
   logic        if_valid_i;
   logic [31:0] if_pc_i;
   logic [31:0] if_inst_i;
   logic        if_ready_o;
   logic        id_valid_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_ready_i;
   logic        flush_i;
   logic [2:0]  count_o;

   int tests = 0;
   int fails = 0;

   if_id_queue #(
      .DEPTH    (4),
      .ADDR_W   (32),
      .INST_W   (32),
      .NOP_INST (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_valid_i (if_valid_i),
      .if_pc_i    (if_pc_i),
      .if_inst_i  (if_inst_i),
      .if_ready_o (if_ready_o),
      .id_valid_o (id_valid_o),
      .id_pc_o    (id_pc_o),
      .id_inst_o  (id_inst_o),
      .id_ready_i (id_ready_i),
      .flush_i    (flush_i),
      .count_o    (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; if_valid_i = 1'b0; if_pc_i = '0; if_inst_i = '0;
      id_ready_i = 1'b0; flush_i = 1'b0;
      #100;
      tests++; if (if_ready_o !== 1'b1) begin fails++; $display("FAIL reset_if_ready got %b exp 1", if_ready_o); end
      tests++; if (id_valid_o !== 1'b0) begin fails++; $display("FAIL reset_id_valid got %b exp 0", id_valid_o); end
      tests++; if (id_pc_o !== 32'h0) begin fails++; $display("FAIL reset_id_pc got %h exp 0", id_pc_o); end
      tests++; if (id_inst_o !== 32'h0) begin fails++; $display("FAIL reset_id_inst got %h exp 0", id_inst_o); end
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count_o); end
      #95;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_stream();
      logic [31:0] pcs   [3];
      logic [31:0] insts [3];
      pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
      insts[0] = 32'h3401_1100; insts[1] = 32'h3402_0020; insts[2] = 32'h3403_ff00;
      id_ready_i = 1'b1;
      tests++; if (id_valid_o !== 1'b0) begin fails++; $display("FAIL stream_pre_valid got %b exp 0", id_valid_o); end
      for (int i = 0; i < 3; i++) begin
         if_valid_i = 1'b1; if_pc_i = pcs[i]; if_inst_i = insts[i];
         tick();
         tests++; if (id_valid_o !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d] got %b exp 1", i, id_valid_o); end
         tests++; if (id_pc_o !== pcs[i]) begin fails++; $display("FAIL stream_pc[%0d] got %h exp %h", i, id_pc_o, pcs[i]); end
         tests++; if (id_inst_o !== insts[i]) begin fails++; $display("FAIL stream_inst[%0d] got %h exp %h", i, id_inst_o, insts[i]); end
         tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count_o); end
      end
      if_valid_i = 1'b0;
      tick();
      tests++; if (id_valid_o !== 1'b0) begin fails++; $display("FAIL stream_drain_valid got %b exp 0", id_valid_o); end
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL stream_drain_count got %0d exp 0", count_o); end
      id_ready_i = 1'b0;
   endtask

   task automatic test_fill();
      logic [2:0] exp_cnt;
      id_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if_valid_i = 1'b1; if_pc_i = 32'(i * 4); if_inst_i = 32'h1000 + 32'(i);
         tick();
         exp_cnt = (i < 4) ? 3'(i + 1) : 3'd4;
         tests++; if (count_o !== exp_cnt) begin fails++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count_o, exp_cnt); end
         tests++; if (id_pc_o !== 32'h00) begin fails++; $display("FAIL fill_head_hold[%0d] got %h exp 0", i, id_pc_o); end
      end
      tests++; if (if_ready_o !== 1'b0) begin fails++; $display("FAIL fill_full_ready got %b exp 0", if_ready_o); end
      if_valid_i = 1'b0; id_ready_i = 1'b1;
      tick();
      id_ready_i = 1'b0;
      tests++; if (if_ready_o !== 1'b1) begin fails++; $display("FAIL fill_after_pop_ready got %b exp 1", if_ready_o); end
      tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL fill_after_pop_count got %0d exp 3", count_o); end
      tests++; if (id_pc_o !== 32'h04) begin fails++; $display("FAIL fill_after_pop_head got %h exp 04", id_pc_o); end
   endtask

   // Starts with 0x04,0x08,0x0C queued.
   task automatic test_simultaneous();
      if_valid_i = 1'b1; if_pc_i = 32'h10; if_inst_i = 32'h2010;
      tick();
      tests++; if (count_o !== 3'd4) begin fails++; $display("FAIL simul_full_count got %0d exp 4", count_o); end
      if_pc_i = 32'h14; if_inst_i = 32'h2014; id_ready_i = 1'b1;
      tick();
      tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL simul_full_pushpop_count got %0d exp 3", count_o); end
      tests++; if (id_pc_o !== 32'h08) begin fails++; $display("FAIL simul_full_pushpop_head got %h exp 08", id_pc_o); end
      if_valid_i = 1'b0;
      tick(); tick();
      tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL simul_drain_count got %0d exp 1", count_o); end
      tests++; if (id_pc_o !== 32'h10) begin fails++; $display("FAIL simul_drain_head got %h exp 10 (refused 14 must not follow)", id_pc_o); end
      if_valid_i = 1'b1; if_pc_i = 32'h18; if_inst_i = 32'h2018;
      tick();
      tests++; if (count_o !== 3'd1) begin fails++; $display("FAIL simul_one_count got %0d exp 1", count_o); end
      tests++; if (id_pc_o !== 32'h18) begin fails++; $display("FAIL simul_one_head got %h exp 18", id_pc_o); end
      tests++; if (id_inst_o !== 32'h2018) begin fails++; $display("FAIL simul_one_inst got %h exp 2018", id_inst_o); end
      if_valid_i = 1'b0;
      tick();
      id_ready_i = 1'b0;
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL simul_empty_count got %0d exp 0", count_o); end
   endtask

   task automatic test_wrap();
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      logic do_push;
      while (got < 10 && cyc < 400) begin
         if_valid_i = (sent < 10) && ($urandom_range(0, 3) != 0);
         if_pc_i    = 32'(sent * 4);
         if_inst_i  = 32'hA000 + 32'(sent);
         id_ready_i = ($urandom_range(0, 2) != 0);
         #1;
         do_push = if_valid_i && if_ready_o;
         if (id_valid_o && id_ready_i) begin
            tests++;
            if (id_pc_o !== 32'(got * 4) || id_inst_o !== 32'hA000 + 32'(got)) begin
               fails++;
               $display("FAIL wrap_order[%0d] got pc %h inst %h exp pc %h inst %h",
                        got, id_pc_o, id_inst_o, 32'(got * 4), 32'hA000 + 32'(got));
            end
            got++;
         end
         tests++; if (count_o > 3'd4) begin fails++; $display("FAIL wrap_count_bound got %0d exp <=4", count_o); end
         tick();
         if (do_push) sent++;
         cyc++;
      end
      if_valid_i = 1'b0; id_ready_i = 1'b0;
      tests++; if (got != 10) begin fails++; $display("FAIL wrap_complete got %0d entries exp 10", got); end
      tick();
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL wrap_final_count got %0d exp 0", count_o); end
   endtask

   task automatic test_flush();
      id_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if_valid_i = 1'b1; if_pc_i = 32'h30 + 32'(i * 4); if_inst_i = 32'hB000 + 32'(i);
         tick();
      end
      tests++; if (count_o !== 3'd3) begin fails++; $display("FAIL flush_pre_count got %0d exp 3", count_o); end
      if_pc_i = 32'h40; if_inst_i = 32'hB040; flush_i = 1'b1; id_ready_i = 1'b1;
      tick();
      flush_i = 1'b0; if_valid_i = 1'b0;
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL flush_count got %0d exp 0", count_o); end
      tests++; if (id_valid_o !== 1'b0) begin fails++; $display("FAIL flush_valid got %b exp 0", id_valid_o); end
      tests++; if (id_inst_o !== 32'h0) begin fails++; $display("FAIL flush_inst got %h exp 0", id_inst_o); end
      tests++; if (if_ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready got %b exp 1", if_ready_o); end
      tick();
      tests++; if (id_valid_o !== 1'b0 || id_pc_o === 32'h40) begin fails++; $display("FAIL flush_no_40 got valid %b pc %h exp valid 0", id_valid_o, id_pc_o); end
      if_valid_i = 1'b1; if_pc_i = 32'h80; if_inst_i = 32'hB080; id_ready_i = 1'b0;
      tick();
      if_valid_i = 1'b0;
      tests++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h80) begin fails++; $display("FAIL flush_then_push got valid %b pc %h exp 1/80", id_valid_o, id_pc_o); end
      id_ready_i = 1'b1;
      tick();
      id_ready_i = 1'b0;
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL flush_final_count got %0d exp 0", count_o); end
   endtask

   task automatic test_async_reset();
      id_ready_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if_valid_i = 1'b1; if_pc_i = 32'h90 + 32'(i * 4); if_inst_i = 32'hC000 + 32'(i);
         tick();
      end
      if_valid_i = 1'b0;
      tests++; if (count_o !== 3'd2) begin fails++; $display("FAIL areset_pre_count got %0d exp 2", count_o); end
      #2 rst = 1'b1;
      #1;
      tests++; if (id_valid_o !== 1'b0) begin fails++; $display("FAIL areset_valid got %b exp 0", id_valid_o); end
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL areset_count got %0d exp 0", count_o); end
      tests++; if (if_ready_o !== 1'b1) begin fails++; $display("FAIL areset_ready got %b exp 1", if_ready_o); end
      @(negedge clk);
      rst = 1'b0;
      tick();
      tests++; if (count_o !== 3'd0) begin fails++; $display("FAIL areset_after_count got %0d exp 0", count_o); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fill();
      test_simultaneous();
      test_wrap();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
